bios_burst_loader: RTL

//  Sits between the SPI data_io download port and the system BIOS write port, on the

---
 rtl/bios_burst_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bios_burst_loader.sv
// Pairs SPI download bytes into 16-bit words, stages them in a ping-pong buffer
// and hands each completed half to the SDRAM BIOS port as one paced burst.
//
// state | meaning
// IDLE  | after reset, waiting for a download to start
// LOAD  | download active, pairing bytes into the buffer
// FLUSH | download ended, pushing a partial half and draining bursts
// DONE  | image fully written, bios_loaded held high
module bios_burst_loader #(
    parameter int BURST_WORDS = 32,
    parameter int ADDR_W      = 13
) (
    input  logic              clk_sdr,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] bios_addr,
    output logic [15:0]       bios_din,
    output logic              bios_wr,
    input  logic              bios_req,
    output logic              bios_loaded,
    output logic              overflow
);

    localparam int WIDX_W = $clog2(2 * BURST_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic              dl_d;
    logic              req_d;
    logic [7:0]        low_byte;
    logic              low_valid;
    logic [WIDX_W-1:0] low_idx;
    logic              dirty;

    logic [15:0]       word_mem [2*BURST_WORDS];
    logic              mem_we;
    logic [WIDX_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;

    logic dl_rise;
    logic burst_end;
    logic half_done;
    logic unused_addr_bits;

    assign dl_rise   = ioctl_download & ~dl_d;
    assign burst_end = req_d & ~bios_req;
    assign half_done = (ioctl_addr[WIDX_W-1:1] == (WIDX_W-1)'(BURST_WORDS - 1));
    assign unused_addr_bits = ^ioctl_addr[24:WIDX_W+1];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ioctl_addr[WIDX_W:1];
        mem_wdata = {ioctl_dout, low_byte};
        if (!dl_rise) begin
            if (state == LOAD && ioctl_wr && ioctl_addr[0]) begin
                mem_we = 1'b1;
            end else if (state == FLUSH && low_valid) begin
                // unpaired trailing byte goes out with a zero high half
                mem_we    = 1'b1;
                mem_waddr = low_idx;
                mem_wdata = {8'h00, low_byte};
            end
        end
    end

    always_ff @(posedge clk_sdr) begin
        if (mem_we) begin
            word_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_sdr) begin
        if (reset) begin
            state       <= IDLE;
            // capture the current level so a download already in progress is not seen as a new one
            dl_d        <= ioctl_download;
            req_d       <= 1'b0;
            bios_addr   <= '0;
            bios_din    <= '0;
            bios_wr     <= 1'b0;
            bios_loaded <= 1'b0;
            overflow    <= 1'b0;
            low_byte    <= '0;
            low_valid   <= 1'b0;
            low_idx     <= '0;
            dirty       <= 1'b0;
        end else begin
            dl_d  <= ioctl_download;
            req_d <= bios_req;

            if (bios_req) begin
                bios_din  <= word_mem[bios_addr[WIDX_W-1:0]];
                bios_addr <= bios_addr + ADDR_W'(1);
            end

            if (burst_end) begin
                bios_wr <= 1'b0;
            end

            if (dl_rise) begin
                state       <= LOAD;
                bios_loaded <= 1'b0;
                bios_addr   <= '0;
                bios_wr     <= 1'b0;
                overflow    <= 1'b0;
                low_byte    <= '0;
                low_valid   <= 1'b0;
                dirty       <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (ioctl_wr) begin
                            if (!ioctl_addr[0]) begin
                                low_byte  <= ioctl_dout;
                                low_valid <= 1'b1;
                                low_idx   <= ioctl_addr[WIDX_W:1];
                            end else begin
                                low_valid <= 1'b0;
                                if (half_done) begin
                                    dirty <= 1'b0;
                                    // a burst that ends this very cycle has drained, so no overflow
                                    if (bios_wr && !burst_end) begin
                                        overflow <= 1'b1;
                                    end else begin
                                        bios_wr <= 1'b1;
                                    end
                                end else begin
                                    dirty <= 1'b1;
                                end
                            end
                        end
                        if (!ioctl_download) begin
                            state <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (low_valid) begin
                            low_valid <= 1'b0;
                            dirty     <= 1'b1;
                        end else if (dirty) begin
                            if (!bios_wr) begin
                                bios_wr <= 1'b1;
                                dirty   <= 1'b0;
                            end
                        end else if (!bios_wr) begin
                            state       <= DONE;
                            bios_loaded <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
